version_slot_controller: RTL and testbench
==========================================

// Module: version_slot_controller
//
// PURPOSE
// - Owns four versioned 32-bit data slots and a monotonically increasing version counter.
// - Write side: each accepted write gets the next version number and is stored, evicting the oldest slot when all four are full.
// - Read side: a request carries readVersion. The response is the data of the newest valid slot whose version is strictly less than readVersion, plus a hit flag.
// - Sits between the requesting pipeline and the priority routing datapath, and sequences all slot updates and lookups.
//
// PARAMETERS
// - BLOCK_SIZE  4  width of version numbers; version range 0..2^BLOCK_SIZE-1.
// - DATA_W     32  width of the data words.
//
// PORTS
// - clk          in   1           single clock, rising edge.
// - rst          in   1           asynchronous, active-high reset.
// - flush        in   1           level request: invalidate all slots and restart versions.
// - wrValid      in   1           write request.
// - wrReady      out  1           write accepted when wrValid & wrReady.
// - wrData       in   DATA_W      data to store.
// - wrVersion    out  BLOCK_SIZE  version the current write will receive (= nextVersion).
// - rdValid      in   1           read request.
// - rdReady      out  1           read accepted when rdValid & rdReady.
// - readVersion  in   BLOCK_SIZE  upper bound for the lookup (exclusive).
// - respValid    out  1           response valid.
// - respReady    in   1           response consumed when respValid & respReady.
// - respData     out  DATA_W      selected slot data; 0 on miss.
// - respHit      out  1           1 if a qualifying slot exists.
// - occupancy    out  3           number of valid slots, 0..4.
//
// BEHAVIOUR
// Reset (async, while rst=1)
// - Every slot is invalid and nextVersion=1. Version 0 is reserved and never stored.
// - saturated=0 and state=IDLE.
// - respValid=0, respData=0, respHit=0, occupancy=0.
// - wrReady=0 and rdReady=0 (both gated by !rst).
//
// State machine: IDLE, RESP, FLUSH
// - IDLE priority order is flush > write > read.
//   - flush=1 -> FLUSH. wrReady=0, rdReady=0.
//   - Otherwise wrReady = !saturated.
//   - Otherwise rdReady = !(wrValid & !saturated). A pending write stalls the read by one cycle, so the read sees the new write.
// - Write accept (stays in IDLE)
//   - Target slot is the lowest-index invalid slot. If all four are valid, the target is the slot with the smallest version.
//   - The slot gets valid=1, version=nextVersion, data=wrData, and nextVersion increments.
//   - When the accepted version is 2^BLOCK_SIZE-1: saturated=1 and nextVersion holds. No wrap, ever.
// - Read accept -> RESP
//   - Select combinationally over the valid slots with version < readVersion, taking the maximum version. Versions are unique, so there are no ties.
//   - respData and respHit are registered on the accept edge; respValid=1 from the next cycle.
//   - If nothing qualifies (including readVersion<=1): respHit=0, respData=0.
// - RESP
//   - respValid=1; respData and respHit are held stable; wrReady=0, rdReady=0.
//   - On respReady=1: respValid=0 and the next state is IDLE. Read throughput is 1 per 2 cycles minimum.
//   - flush asserted during RESP is not acted on until the FSM is back in IDLE.
// - FLUSH (exactly 1 cycle)
//   - Clears all valid bits; nextVersion=1; saturated=0; next state IDLE.
//   - If flush is still high in IDLE, FLUSH is re-entered.
// - Continuous signals
//   - occupancy is a registered popcount of the valid bits, updated the same edge as the slot change.
//   - wrVersion = nextVersion at all times.
// - rst asserted mid-RESP or mid-FLUSH returns to the reset values immediately; a pending response is dropped.
//
// STRUCTURE
// - Shared package version_pkg:
//   - SLOT_COUNT=4
//   - version_t (BLOCK_SIZE bits)
//   - slot_t {valid, version, data}
//   - state encoding {IDLE, RESP, FLUSH}
//   - VERSION_RESERVED=0
// - Sub-module version_select (combinational): slot array + readVersion -> {hit, data, index}. Reused by the routing datapath.
// - Victim choice (invalid-first, else min-version) stays inline in this module.
//
// TESTING
// 1. Reset, write 0xA,0xB,0xC (versions 1,2,3); read readVersion=3 -> respHit=1, respData=0xB.
// 2. After test 1: readVersion=1 and readVersion=0 -> respHit=0, respData=0; readVersion=15 -> respData=0xC.
// 3. Write 5 words 0x1..0x5 -> the version-1 slot is evicted, occupancy=4; readVersion=2 -> miss; readVersion=6 -> 0x5.
// 4. wrValid=rdValid=1 in the same IDLE cycle -> write accepted, rdReady=0; read accepted next cycle and returns the new write.
// 5. Write 15 words (BLOCK_SIZE=4) -> wrReady=0 after version 15; pulse flush -> occupancy=0 after FLUSH, next write gets wrVersion=1.
// 6. respReady=0 for 3 cycles -> respValid, respData, respHit stable, rdReady=0; assert rst mid-RESP -> respValid=0 asynchronously.

Source files
------------

// File: rtl/version_pkg.sv
// Shared types and constants for the versioned slot store and its lookup logic.
package version_pkg;

  localparam int BLOCK_SIZE = 4;
  localparam int DATA_W     = 32;
  localparam int SLOT_COUNT = 4;
  localparam int IDX_W      = $clog2(SLOT_COUNT);

  typedef logic [BLOCK_SIZE-1:0] version_t;

  // Version 0 is never stored, so "readVersion <= 1" can never hit.
  localparam version_t VERSION_RESERVED = '0;
  localparam version_t VERSION_FIRST    = version_t'(1);
  localparam version_t VERSION_MAX      = '1;

  typedef struct packed {
    logic              valid;
    version_t          version;
    logic [DATA_W-1:0] data;
  } slot_t;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    FLUSH
  } state_t;

  function automatic logic [2:0] popCount(input logic [SLOT_COUNT-1:0] bits);
    logic [2:0] count;
    count = '0;
    for (int i = 0; i < SLOT_COUNT; i++) count = count + 3'(bits[i]);
    return count;
  endfunction

endpackage

// File: rtl/version_select.sv
// Combinational lookup: newest valid slot whose version is strictly below readVersion.
module version_select
  import version_pkg::*;
(
  input  slot_t [SLOT_COUNT-1:0] slots,
  input  version_t               readVersion,
  output logic                   hit,
  output logic [DATA_W-1:0]      data,
  output logic [IDX_W-1:0]       index
);

  version_t bestVersion;

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    hit         = 1'b0;
    data        = '0;
    index       = '0;
    bestVersion = VERSION_RESERVED;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      if (slots[i].valid && (slots[i].version < readVersion) &&
          (!hit || (slots[i].version > bestVersion))) begin
        hit         = 1'b1;
        bestVersion = slots[i].version;
        data        = slots[i].data;
        index       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/version_slot_controller.sv
// Four-slot versioned store: versioned writes with oldest-first eviction,
// bounded-version reads, and a one-cycle flush, sequenced by a small FSM.
module version_slot_controller
  import version_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wrValid,
  output logic                  wrReady,
  input  logic [DATA_W-1:0]     wrData,
  output logic [BLOCK_SIZE-1:0] wrVersion,
  input  logic                  rdValid,
  output logic                  rdReady,
  input  logic [BLOCK_SIZE-1:0] readVersion,
  output logic                  respValid,
  input  logic                  respReady,
  output logic [DATA_W-1:0]     respData,
  output logic                  respHit,
  output logic [2:0]            occupancy
);

  state_t                  state, nextState;
  version_t                nextVersion;
  logic                    saturated;
  logic [SLOT_COUNT-1:0]   validBits, nextValidBits;
  version_t                slotVersion [SLOT_COUNT];
  logic [DATA_W-1:0]       slotData    [SLOT_COUNT];
  slot_t [SLOT_COUNT-1:0]  slotView;
  logic [IDX_W-1:0]        victim;
  logic                    wrAccept, rdAccept;
  logic                    selHit;
  logic [DATA_W-1:0]       selData;
  logic [IDX_W-1:0]        unusedSelIndex;

  assign wrVersion = nextVersion;
  assign wrAccept  = wrValid & wrReady;
  assign rdAccept  = rdValid & rdReady;

  always_comb begin
    nextState = state;
    wrReady   = 1'b0;
    rdReady   = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush) begin
          nextState = FLUSH;
        end else begin
          wrReady = !saturated;
          // A write in the same cycle goes first so the read observes it.
          rdReady = !(wrValid && !saturated);
          if (rdValid && rdReady) nextState = RESP;
        end
      end
      RESP:    if (respReady) nextState = IDLE;
      FLUSH:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (rst) begin
      wrReady = 1'b0;
      rdReady = 1'b0;
    end
  end

  // Victim: lowest-index free slot, otherwise the oldest (smallest) version.
  always_comb begin
    version_t minVersion;
    logic     foundFree;
    victim     = '0;
    foundFree  = 1'b0;
    minVersion = VERSION_MAX;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      if (!validBits[i] && !foundFree) begin
        victim    = IDX_W'(i);
        foundFree = 1'b1;
      end
    end
    if (!foundFree) begin
      for (int i = 0; i < SLOT_COUNT; i++) begin
        if (slotVersion[i] <= minVersion) begin
          victim     = IDX_W'(i);
          minVersion = slotVersion[i];
        end
      end
    end
  end

  always_comb begin
    nextValidBits = validBits;
    if (state == FLUSH)  nextValidBits = '0;
    else if (wrAccept)   nextValidBits[victim] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < SLOT_COUNT; i++) begin
      slotView[i] = '{valid: validBits[i], version: slotVersion[i], data: slotData[i]};
    end
  end

  version_select uSelect (
    .slots       (slotView),
    .readVersion (readVersion),
    .hit         (selHit),
    .data        (selData),
    .index       (unusedSelIndex)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      nextVersion <= VERSION_FIRST;
      saturated   <= 1'b0;
      validBits   <= '0;
      occupancy   <= '0;
      respValid   <= 1'b0;
      respData    <= '0;
      respHit     <= 1'b0;
    end else begin
      state     <= nextState;
      validBits <= nextValidBits;
      occupancy <= popCount(nextValidBits);
      if (state == FLUSH) begin
        nextVersion <= VERSION_FIRST;
        saturated   <= 1'b0;
      end else if (wrAccept) begin
        if (nextVersion == VERSION_MAX) saturated <= 1'b1;
        else                            nextVersion <= nextVersion + version_t'(1);
      end
      if (rdAccept) begin
        respValid <= 1'b1;
        respData  <= selData;
        respHit   <= selHit;
      end else if (state == RESP && respReady) begin
        respValid <= 1'b0;
      end
    end
  end

  // NOTE: slot payload needs no reset; the valid bits alone gate every use.
  always_ff @(posedge clk) begin
    if (wrAccept) begin
      slotVersion[victim] <= nextVersion;
      slotData[victim]    <= wrData;
    end
  end

endmodule

// File: tb/tb_version_slot_controller.sv
// Directed bench for version_slot_controller with a response scoreboard.
module tb_version_slot_controller;
  import version_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, wrValid, wrReady, rdValid, rdReady;
  logic        respValid, respReady, respHit;
  logic [31:0] wrData, respData;
  logic [3:0]  wrVersion, readVersion;
  logic [2:0]  occupancy;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic        hit;
    logic [31:0] data;
  } resp_t;
  resp_t expQ[$];

  always #5 clk = ~clk;

  version_slot_controller dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wrValid(wrValid), .wrReady(wrReady), .wrData(wrData), .wrVersion(wrVersion),
    .rdValid(rdValid), .rdReady(rdReady), .readVersion(readVersion),
    .respValid(respValid), .respReady(respReady), .respData(respData),
    .respHit(respHit), .occupancy(occupancy)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && respValid === 1'b1 && respReady === 1'b1) begin
      if (expQ.size() == 0) begin
        check("unexpected response", {31'b0, respValid}, 32'd0);
      end else begin
        resp_t e;
        e = expQ.pop_front();
        check("resp hit", {31'b0, respHit}, {31'b0, e.hit});
        check("resp data", respData, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input logic [31:0] data);
    wrValid = 1'b1;
    wrData  = data;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (wrReady) break;
    end
    if (!wrReady) check("write accept timeout", {31'b0, wrReady}, 32'd1);
    tick();
    wrValid = 1'b0;
  endtask

  task automatic waitResponse();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (respValid) break;
    end
    if (!respValid) check("response timeout", {31'b0, respValid}, 32'd1);
    tick();
  endtask

  task automatic doRead(input logic [3:0] rv, input logic hit, input logic [31:0] data);
    expQ.push_back('{hit: hit, data: data});
    rdValid     = 1'b1;
    readVersion = rv;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rdReady) break;
    end
    if (!rdReady) check("read accept timeout", {31'b0, rdReady}, 32'd1);
    tick();
    rdValid = 1'b0;
    waitResponse();
  endtask

  task automatic flushPulse();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wrValid = 1'b0; rdValid = 1'b0;
    respReady = 1'b1; wrData = '0; readVersion = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset wrReady", {31'b0, wrReady}, 32'd0);
    check("reset rdReady", {31'b0, rdReady}, 32'd0);
    check("reset respValid", {31'b0, respValid}, 32'd0);
    check("reset occupancy", {29'b0, occupancy}, 32'd0);
    check("reset wrVersion", {28'b0, wrVersion}, 32'd1);
    rst = 1'b0;
    #1;
    check("idle wrReady", {31'b0, wrReady}, 32'd1);

    // Three writes, then bounded reads.
    doWrite(32'hA); doWrite(32'hB); doWrite(32'hC);
    check("occupancy after 3", {29'b0, occupancy}, 32'd3);
    check("wrVersion after 3", {28'b0, wrVersion}, 32'd4);
    doRead(4'd3, 1'b1, 32'hB);
    doRead(4'd1, 1'b0, 32'h0);
    doRead(4'd0, 1'b0, 32'h0);
    doRead(4'd15, 1'b1, 32'hC);

    // Eviction of the oldest slot from a fresh start.
    flushPulse();
    check("occupancy after flush", {29'b0, occupancy}, 32'd0);
    for (int i = 1; i <= 5; i++) doWrite(32'(i));
    check("occupancy after 5", {29'b0, occupancy}, 32'd4);
    check("wrVersion after 5", {28'b0, wrVersion}, 32'd6);
    doRead(4'd2, 1'b0, 32'h0);
    doRead(4'd6, 1'b1, 32'h5);

    // Simultaneous write and read: the write wins, the read sees it.
    expQ.push_back('{hit: 1'b1, data: 32'h66});
    wrValid = 1'b1; wrData = 32'h66; rdValid = 1'b1; readVersion = 4'd15;
    @(negedge clk);
    check("same-cycle wrReady", {31'b0, wrReady}, 32'd1);
    check("same-cycle rdReady", {31'b0, rdReady}, 32'd0);
    tick();
    wrValid = 1'b0;
    @(negedge clk);
    check("stalled read rdReady", {31'b0, rdReady}, 32'd1);
    tick();
    rdValid = 1'b0;
    waitResponse();
    check("occupancy after evict write", {29'b0, occupancy}, 32'd4);

    // Saturation at the top version, then recovery through flush.
    flushPulse();
    for (int i = 1; i <= 15; i++) doWrite(32'h100 + 32'(i));
    check("saturated wrReady", {31'b0, wrReady}, 32'd0);
    check("saturated wrVersion", {28'b0, wrVersion}, 32'd15);
    check("saturated occupancy", {29'b0, occupancy}, 32'd4);
    doRead(4'd15, 1'b1, 32'h10E);
    flushPulse();
    check("post-flush occupancy", {29'b0, occupancy}, 32'd0);
    check("post-flush wrVersion", {28'b0, wrVersion}, 32'd1);
    check("post-flush wrReady", {31'b0, wrReady}, 32'd1);
    doWrite(32'hD00D);
    check("wrVersion after restart", {28'b0, wrVersion}, 32'd2);

    // Back-pressured response, then reset in the middle of it.
    respReady = 1'b0;
    rdValid = 1'b1; readVersion = 4'd15;
    @(negedge clk);
    check("held read rdReady", {31'b0, rdReady}, 32'd1);
    tick();
    rdValid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("held respValid", {31'b0, respValid}, 32'd1);
      check("held respData", respData, 32'hD00D);
      check("held respHit", {31'b0, respHit}, 32'd1);
      check("held rdReady", {31'b0, rdReady}, 32'd0);
    end
    tick();
    rst = 1'b1;
    #1;
    check("async reset respValid", {31'b0, respValid}, 32'd0);
    check("async reset occupancy", {29'b0, occupancy}, 32'd0);
    tick();
    rst = 1'b0;
    respReady = 1'b1;
    #1;
    check("reset wrVersion again", {28'b0, wrVersion}, 32'd1);
    tick();

    check("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
